// File: rtl/pll_lock_seq.sv
// PLL control sequencer: config handshake, lock debounce/timeout/retry, loss-of-lock detection
// and phase-aligned per-channel clock enables. Define PLL_LOCK_CNT_EN to build the loss-of-lock counter.
module pll_lock_seq #(
   parameter int NUM_CH       = 2,
   parameter int MUL_W        = 8,
   parameter int DIV_W        = 8,
   parameter int RST_CYCLES   = 4,
   parameter int LOCK_DELAY   = 3,
   parameter int LOCK_TIMEOUT = 16,
   parameter int MAX_RETRY    = 2
) (
   input  logic                    xo_clk,
   input  logic                    reset,
   input  logic                    pll_enable,
   input  logic                    pll_bypass,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   input  logic [MUL_W-1:0]        cfg_mul,
   input  logic [DIV_W-1:0]        cfg_div,
   input  logic [NUM_CH*DIV_W-1:0] cfg_ch_div,
   input  logic                    ana_lock,
   output logic [MUL_W-1:0]        pll_mul_o,
   output logic [DIV_W-1:0]        pll_div_o,
   output logic                    pll_rst_o,
   output logic                    pll_locked,
   output logic                    pll_error,
   output logic [1:0]              err_code,
   output logic                    lock_lost,
   output logic [NUM_CH-1:0]       ch_ce,
   output logic [7:0]              lock_loss_cnt
);

   typedef enum logic [2:0] {IDLE, RESET_PLL, WAIT_LOCK, LOCKED, BYPASS, ERROR} state_t;

   localparam int RC_W = $clog2(RST_CYCLES + 2);
   localparam int DB_W = $clog2(LOCK_DELAY + 2);
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 2);
   localparam int RT_W = $clog2(MAX_RETRY + 2);

   state_t                  state, state_nxt;
   logic [RC_W-1:0]         rst_cnt;
   logic [DB_W-1:0]         deb_cnt, deb_inc;
   logic [TO_W-1:0]         to_cnt, to_inc;
   logic [RT_W-1:0]         retry;
   logic [NUM_CH*DIV_W-1:0] ch_div;
   logic [DIV_W-1:0]        ch_cnt [NUM_CH];
   logic                    cfg_ok, xfer, cfg_bad, lock_hit, tmo_hit;
   logic                    loss_evt, retry_up, ch_act, ch_run;

   assign cfg_ready = pll_enable && (state inside {IDLE, LOCKED, BYPASS, ERROR});
   assign xfer      = cfg_valid && cfg_ready;
   assign cfg_bad   = (cfg_mul == '0) || (cfg_div == '0);
   assign deb_inc   = ana_lock ? deb_cnt + 1'b1 : '0;
   assign to_inc    = to_cnt + 1'b1;
   assign lock_hit  = (deb_inc == DB_W'(LOCK_DELAY));
   assign tmo_hit   = (to_inc == TO_W'(LOCK_TIMEOUT));
   assign ch_act    = state inside {LOCKED, BYPASS};
   // counters only advance while staying put, so every entry starts all channels from zero
   assign ch_run    = ch_act && (state_nxt == state) && !xfer;

   always_ff @(posedge xo_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      loss_evt  = 1'b0;
      retry_up  = 1'b0;
      if (!pll_enable)     state_nxt = IDLE;
      else if (pll_bypass) state_nxt = BYPASS;
      else if (xfer)       state_nxt = cfg_bad ? ERROR : RESET_PLL;
      else begin
         case (state)
            RESET_PLL: if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lock_hit) state_nxt = LOCKED;
               else if (tmo_hit) begin
                  if (retry < RT_W'(MAX_RETRY)) begin
                     state_nxt = RESET_PLL;
                     retry_up  = 1'b1;
                  end else begin
                     state_nxt = ERROR;
                  end
               end
            end
            LOCKED: begin
               if (!ana_lock) begin
                  state_nxt = RESET_PLL;
                  loss_evt  = 1'b1;
               end
            end
            BYPASS:  state_nxt = cfg_ok ? RESET_PLL : IDLE;
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge xo_clk or posedge reset) begin
      if (reset) begin
         pll_mul_o  <= '0;
         pll_div_o  <= '0;
         ch_div     <= '0;
         cfg_ok     <= 1'b0;
         pll_rst_o  <= 1'b1;
         pll_locked <= 1'b0;
         pll_error  <= 1'b0;
         err_code   <= '0;
         lock_lost  <= 1'b0;
         retry      <= '0;
         rst_cnt    <= '0;
         deb_cnt    <= '0;
         to_cnt     <= '0;
      end else begin
         if (xfer) begin
            pll_mul_o <= cfg_mul;
            pll_div_o <= cfg_div;
            ch_div    <= cfg_ch_div;
            cfg_ok    <= !cfg_bad;
         end
         pll_rst_o  <= !(state_nxt inside {WAIT_LOCK, LOCKED});
         pll_locked <= (state_nxt == LOCKED) ||
                       ((state_nxt == BYPASS) && (state inside {LOCKED, BYPASS}));
         pll_error  <= (state_nxt == ERROR);
         // code is fixed on entry to ERROR; a bad transfer while in ERROR re-marks it
         if (state_nxt != ERROR)  err_code <= 2'd0;
         else if (xfer)           err_code <= 2'd1;
         else if (state != ERROR) err_code <= 2'd2;
         if (xfer)          lock_lost <= 1'b0;
         else if (loss_evt) lock_lost <= 1'b1;
         if (xfer || loss_evt) retry <= '0;
         else if (retry_up)    retry <= retry + 1'b1;
         rst_cnt <= (state == RESET_PLL && state_nxt == RESET_PLL) ? rst_cnt + 1'b1 : '0;
         if (state == WAIT_LOCK && state_nxt == WAIT_LOCK) begin
            deb_cnt <= deb_inc;
            to_cnt  <= to_inc;
         end else begin
            deb_cnt <= '0;
            to_cnt  <= '0;
         end
      end
   end

   always_ff @(posedge xo_clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) ch_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_run && ch_div[i*DIV_W +: DIV_W] >= DIV_W'(2) &&
                ch_cnt[i] != ch_div[i*DIV_W +: DIV_W] - 1'b1)
               ch_cnt[i] <= ch_cnt[i] + 1'b1;
            else
               ch_cnt[i] <= '0;
         end
      end
   end

   always_comb begin
      ch_ce = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_ce[i] = pll_enable && ch_act &&
                    ((ch_div[i*DIV_W +: DIV_W] == DIV_W'(1)) ||
                     (ch_div[i*DIV_W +: DIV_W] >= DIV_W'(2) &&
                      ch_cnt[i] == ch_div[i*DIV_W +: DIV_W] - 1'b1));
      end
   end

`ifdef PLL_LOCK_CNT_EN
   always_ff @(posedge xo_clk or posedge reset) begin
      if (reset)                                   lock_loss_cnt <= '0;
      else if (loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 1'b1;
   end
`else
   assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed self-checking bench for pll_lock_seq with default parameters.
module tb_pll_lock_seq;

`ifdef PLL_LOCK_CNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic        xo_clk = 1'b0;
   logic        reset = 1'b1, pll_enable = 1'b0, pll_bypass = 1'b0;
   logic        cfg_valid = 1'b0, ana_lock = 1'b0;
   logic [7:0]  cfg_mul = '0, cfg_div = '0;
   logic [15:0] cfg_ch_div = '0;
   logic        cfg_ready, pll_rst_o, pll_locked, pll_error, lock_lost;
   logic [7:0]  pll_mul_o, pll_div_o, lock_loss_cnt;
   logic [1:0]  err_code, ch_ce, exp_ce;
   logic        exp_rst;
   int          checks = 0, errors = 0;

   pll_lock_seq #(
      .NUM_CH(2), .MUL_W(8), .DIV_W(8), .RST_CYCLES(4),
      .LOCK_DELAY(3), .LOCK_TIMEOUT(16), .MAX_RETRY(2)
   ) dut (
      .xo_clk(xo_clk), .reset(reset), .pll_enable(pll_enable), .pll_bypass(pll_bypass),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mul(cfg_mul), .cfg_div(cfg_div),
      .cfg_ch_div(cfg_ch_div), .ana_lock(ana_lock), .pll_mul_o(pll_mul_o),
      .pll_div_o(pll_div_o), .pll_rst_o(pll_rst_o), .pll_locked(pll_locked),
      .pll_error(pll_error), .err_code(err_code), .lock_lost(lock_lost), .ch_ce(ch_ce),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 xo_clk = ~xo_clk;

   task automatic step();
      @(posedge xo_clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; pll_enable = 1'b1;
      #12;
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL reset_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0h exp 0", pll_locked); end
      checks++; if (pll_mul_o !== 8'd0) begin errors++; $display("FAIL reset_mul: got %0h exp 0", pll_mul_o); end
      checks++; if (pll_div_o !== 8'd0) begin errors++; $display("FAIL reset_div: got %0h exp 0", pll_div_o); end
      checks++; if (pll_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0h exp 0", pll_error); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0h exp 0", err_code); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL reset_lost: got %0h exp 0", lock_lost); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL reset_ce: got %0h exp 0", ch_ce); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL reset_losscnt: got %0h exp 0", lock_loss_cnt); end
      @(negedge xo_clk); reset = 1'b0;
      step();
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %0h exp 1", cfg_ready); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL idle_rst: got %0h exp 1", pll_rst_o); end
   endtask

   task automatic test_happy();
      cfg_mul = 8'd8; cfg_div = 8'd2; cfg_ch_div = {8'd3, 8'd1}; ana_lock = 1'b1; cfg_valid = 1'b1;
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL happy_ready: got %0h exp 1", cfg_ready); end
      step(); cfg_valid = 1'b0;
      checks++; if (pll_mul_o !== 8'd8) begin errors++; $display("FAIL happy_mul: got %0d exp 8", pll_mul_o); end
      checks++; if (pll_div_o !== 8'd2) begin errors++; $display("FAIL happy_div: got %0d exp 2", pll_div_o); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL happy_busy: got %0h exp 0", cfg_ready); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL happy_rst_hi%0d: got %0h exp 1", i, pll_rst_o); end
         step();
      end
      checks++; if (pll_rst_o !== 1'b0) begin errors++; $display("FAIL happy_rst_lo: got %0h exp 0", pll_rst_o); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL happy_prelock%0d: got %0h exp 0", i, pll_locked); end
         step();
      end
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL happy_locked: got %0h exp 1", pll_locked); end
      for (int k = 1; k <= 9; k++) begin
         exp_ce[1] = (k % 3 == 0); exp_ce[0] = 1'b1;
         checks++; if (ch_ce !== exp_ce) begin errors++; $display("FAIL happy_ce_c%0d: got %b exp %b", k, ch_ce, exp_ce); end
         step();
      end
   endtask

   task automatic test_loss();
      ana_lock = 1'b0; step(); ana_lock = 1'b1;
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %0h exp 0", pll_locked); end
      checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_flag: got %0h exp 1", lock_lost); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL loss_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL loss_ce: got %b exp 00", ch_ce); end
      repeat (6) step();
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL loss_relock_early: got %0h exp 0", pll_locked); end
      step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL loss_relock: got %0h exp 1", pll_locked); end
      checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL loss_sticky: got %0h exp 1", lock_lost); end
      checks++; if (lock_loss_cnt !== 8'(CNT_EN)) begin errors++; $display("FAIL loss_cnt: got %0d exp %0d", lock_loss_cnt, CNT_EN); end
   endtask

   task automatic test_xfer_wins();
      cfg_mul = 8'd5; cfg_div = 8'd3; cfg_ch_div = {8'd2, 8'd0}; cfg_valid = 1'b1; ana_lock = 1'b0;
      step(); cfg_valid = 1'b0; ana_lock = 1'b1;
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL xw_locked: got %0h exp 0", pll_locked); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL xw_lost: got %0h exp 0", lock_lost); end
      checks++; if (pll_mul_o !== 8'd5) begin errors++; $display("FAIL xw_mul: got %0d exp 5", pll_mul_o); end
      checks++; if (pll_div_o !== 8'd3) begin errors++; $display("FAIL xw_div: got %0d exp 3", pll_div_o); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL xw_rst: got %0h exp 1", pll_rst_o); end
      repeat (7) step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL xw_relock: got %0h exp 1", pll_locked); end
      for (int k = 1; k <= 4; k++) begin
         exp_ce[1] = (k % 2 == 0); exp_ce[0] = 1'b0;
         checks++; if (ch_ce !== exp_ce) begin errors++; $display("FAIL xw_ce_c%0d: got %b exp %b", k, ch_ce, exp_ce); end
         step();
      end
   endtask

   task automatic test_bad_cfg();
      cfg_mul = 8'd7; cfg_div = 8'd0; cfg_valid = 1'b1;
      step(); cfg_valid = 1'b0;
      checks++; if (pll_error !== 1'b1) begin errors++; $display("FAIL bad_error: got %0h exp 1", pll_error); end
      checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL bad_code: got %0d exp 1", err_code); end
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL bad_locked: got %0h exp 0", pll_locked); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL bad_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (pll_mul_o !== 8'd7) begin errors++; $display("FAIL bad_mul: got %0d exp 7", pll_mul_o); end
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ready: got %0h exp 1", cfg_ready); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL bad_ce: got %b exp 00", ch_ce); end
      repeat (3) step();
      checks++; if (err_code !== 2'd1) begin errors++; $display("FAIL bad_code_hold: got %0d exp 1", err_code); end
      checks++; if (pll_error !== 1'b1) begin errors++; $display("FAIL bad_error_hold: got %0h exp 1", pll_error); end
   endtask

   task automatic test_timeout();
      cfg_mul = 8'd8; cfg_div = 8'd2; cfg_ch_div = {8'd3, 8'd1}; cfg_valid = 1'b1; ana_lock = 1'b0;
      step(); cfg_valid = 1'b0;
      checks++; if (pll_error !== 1'b0) begin errors++; $display("FAIL to_clear_error: got %0h exp 0", pll_error); end
      checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL to_clear_code: got %0d exp 0", err_code); end
      for (int e = 1; e <= 60; e++) begin
         exp_rst = (((e - 1) % 20) < 4);
         checks++; if (pll_rst_o !== exp_rst) begin errors++; $display("FAIL to_rst_e%0d: got %0h exp %0h", e, pll_rst_o, exp_rst); end
         checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL to_nolock_e%0d: got %0h exp 0", e, pll_locked); end
         ana_lock = ((e % 3) != 0);
         step();
      end
      checks++; if (pll_error !== 1'b1) begin errors++; $display("FAIL to_error: got %0h exp 1", pll_error); end
      checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL to_code: got %0d exp 2", err_code); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL to_rst_err: got %0h exp 1", pll_rst_o); end
      repeat (2) step();
      checks++; if (err_code !== 2'd2) begin errors++; $display("FAIL to_code_hold: got %0d exp 2", err_code); end
   endtask

   task automatic test_bypass();
      ana_lock = 1'b0; cfg_valid = 1'b1;
      step(); cfg_valid = 1'b0;
      repeat (5) step();
      checks++; if (pll_rst_o !== 1'b0) begin errors++; $display("FAIL byp_wait_rst: got %0h exp 0", pll_rst_o); end
      pll_bypass = 1'b1;
      step();
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL byp_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (ch_ce !== 2'b01) begin errors++; $display("FAIL byp_ce_c1: got %b exp 01", ch_ce); end
      step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL byp_locked: got %0h exp 1", pll_locked); end
      checks++; if (ch_ce !== 2'b01) begin errors++; $display("FAIL byp_ce_c2: got %b exp 01", ch_ce); end
      step();
      checks++; if (ch_ce !== 2'b11) begin errors++; $display("FAIL byp_ce_c3: got %b exp 11", ch_ce); end
      pll_bypass = 1'b0;
      step();
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL byp_exit_locked: got %0h exp 0", pll_locked); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL byp_exit_ce: got %b exp 00", ch_ce); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL byp_exit_ready: got %0h exp 0", cfg_ready); end
   endtask

   task automatic test_enable();
      ana_lock = 1'b1;
      repeat (7) step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL en_locked: got %0h exp 1", pll_locked); end
      pll_enable = 1'b0;
      #1;
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL en_ready_now: got %0h exp 0", cfg_ready); end
      step();
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL en_locked_off: got %0h exp 0", pll_locked); end
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL en_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL en_ce: got %b exp 00", ch_ce); end
      checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL en_ready: got %0h exp 0", cfg_ready); end
      pll_enable = 1'b1;
      #1;
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL en_idle_ready: got %0h exp 1", cfg_ready); end
   endtask

   task automatic test_reset_mid();
      cfg_valid = 1'b1;
      step(); cfg_valid = 1'b0;
      repeat (7) step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL rm_locked: got %0h exp 1", pll_locked); end
      ana_lock = 1'b0; step(); ana_lock = 1'b1;
      repeat (7) step();
      checks++; if (pll_locked !== 1'b1) begin errors++; $display("FAIL rm_relock: got %0h exp 1", pll_locked); end
      checks++; if (lock_loss_cnt !== 8'(2 * CNT_EN)) begin errors++; $display("FAIL rm_losscnt: got %0d exp %0d", lock_loss_cnt, 2 * CNT_EN); end
      #2 reset = 1'b1;
      #1;
      checks++; if (pll_rst_o !== 1'b1) begin errors++; $display("FAIL rm_rst: got %0h exp 1", pll_rst_o); end
      checks++; if (pll_locked !== 1'b0) begin errors++; $display("FAIL rm_locked_clr: got %0h exp 0", pll_locked); end
      checks++; if (pll_mul_o !== 8'd0) begin errors++; $display("FAIL rm_mul: got %0d exp 0", pll_mul_o); end
      checks++; if (pll_div_o !== 8'd0) begin errors++; $display("FAIL rm_div: got %0d exp 0", pll_div_o); end
      checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL rm_lost: got %0h exp 0", lock_lost); end
      checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL rm_losscnt_clr: got %0d exp 0", lock_loss_cnt); end
      checks++; if (ch_ce !== 2'b00) begin errors++; $display("FAIL rm_ce: got %b exp 00", ch_ce); end
      @(negedge xo_clk); reset = 1'b0;
      step();
      checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %0h exp 1", cfg_ready); end
   endtask

   initial begin
      test_reset();
      test_happy();
      test_loss();
      test_xfer_wins();
      test_bad_cfg();
      test_timeout();
      test_bypass();
      test_enable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pll_lock_seq.md
Name: pll_lock_seq

Overview:
- Parametrised, synthesizable PLL control sequencer; successor to the behavioural PLL model.
- Accepts mul/div configuration through a valid/ready handshake and drives the analog PLL macro (mul, div, reset).
- Qualifies the macro's raw lock with debounce, timeout and bounded retry, and detects loss of lock.
- Generates NUM_CH phase-aligned clock-enable outputs, each with its own divide ratio, for the downstream clock tree in the xo_clk domain.

Parameters:
- NUM_CH, 2, number of divided clock-enable channels (1..8)
- MUL_W, 8, width of the multiplier field
- DIV_W, 8, width of the PLL divider field and of each channel divider
- RST_CYCLES, 4, cycles pll_rst_o is held high per lock attempt (>=1)
- LOCK_DELAY, 3, consecutive ana_lock-high samples needed to declare lock (>=1)
- LOCK_TIMEOUT, 16, cycles in WAIT_LOCK before the attempt fails (>LOCK_DELAY)
- MAX_RETRY, 2, extra lock attempts after the first before ERROR

Ports:
- xo_clk  in  1  reference clock, the only clock
- reset  in  1  asynchronous, active-high reset
- pll_enable  in  1  sequencer enable
- pll_bypass  in  1  bypass request; xo_clk drives the channels
- cfg_valid  in  1  configuration valid
- cfg_ready  out  1  configuration ready; combinational
- cfg_mul  in  MUL_W  PLL multiplier
- cfg_div  in  DIV_W  PLL pre-divider
- cfg_ch_div  in  NUM_CH*DIV_W  per-channel divide ratios, channel 0 in the LSBs
- ana_lock  in  1  raw lock from the analog macro, already synchronised
- pll_mul_o  out  MUL_W  registered multiplier to the macro
- pll_div_o  out  DIV_W  registered divider to the macro
- pll_rst_o  out  1  macro reset
- pll_locked  out  1  qualified lock
- pll_error  out  1  error flag
- err_code  out  2  error code: 0 none, 1 bad config, 2 lock timeout
- lock_lost  out  1  sticky loss-of-lock flag
- ch_ce  out  NUM_CH  per-channel clock-enable pulses
- lock_loss_cnt  out  8  loss-of-lock event counter (see Optional Feature)

Behaviour:
- Reset: state IDLE. pll_rst_o=1. All other registered outputs 0, including pll_mul_o, pll_div_o, the channel ratios, the counters and the retry count.
- States: IDLE, RESET_PLL, WAIT_LOCK, LOCKED, BYPASS, ERROR.
- cfg_ready = pll_enable && state in {IDLE, LOCKED, BYPASS, ERROR}. A transfer occurs when cfg_valid && cfg_ready at a rising edge.
- Priority each cycle, highest first:
  1. reset
  2. !pll_enable: next state IDLE; pll_locked, ch_ce, error, err_code clear; pll_rst_o=1
  3. pll_bypass: next state BYPASS
  4. config transfer
  5. state-specific logic
- Config transfer: latch cfg_mul into pll_mul_o, cfg_div into pll_div_o, and the channel ratios; clear lock_lost and the retry count.
  - cfg_mul==0 or cfg_div==0: go to ERROR, err_code=1.
  - Otherwise go to RESET_PLL. A transfer from LOCKED drops pll_locked on the same edge.
- IDLE: pll_rst_o=1; wait for a transfer.
- RESET_PLL: pll_rst_o=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK: pll_rst_o=0. The timeout counter increments every cycle. The debounce counter increments while ana_lock=1 and clears when ana_lock=0.
  - Debounce reaches LOCK_DELAY: go to LOCKED; pll_locked=1 on that edge.
  - Timeout counter reaches LOCK_TIMEOUT first: retry<MAX_RETRY gives retry+1 and RESET_PLL; otherwise ERROR with err_code=2.
  - Both on the same cycle: lock wins.
- LOCKED: pll_locked=1.
  - ana_lock=0 for one cycle: pll_locked=0 on the next edge, lock_lost=1 (sticky), retry cleared, go to RESET_PLL.
  - A config transfer on the same cycle wins, and lock_lost is not set.
- BYPASS: pll_locked=1 the edge after entry; pll_rst_o=1; ch_ce runs. When pll_bypass falls: go to RESET_PLL if a valid config is latched, else IDLE.
- ERROR: pll_error=1, pll_rst_o=1, ch_ce=0. Leave only via a config transfer or !pll_enable. err_code holds until that exit.
- ch_ce[i]:
  - Active only in LOCKED or BYPASS.
  - All channel counters zero on entry to either state, so channels are phase-aligned.
  - Ratio d=0: channel held at 0. d=1: ce high every cycle. d>=2: one-cycle pulse every d cycles, first pulse on the d-th cycle after entry.
  - Counters are DIV_W wide, wrap d-1 to 0, and are cleared on leaving the state.

Optional Feature:
- Macro PLL_LOCK_CNT_EN.
- Defined: lock_loss_cnt increments on each LOCKED-to-RESET_PLL transition caused by ana_lock loss, saturates at 255, and clears only on reset.
- Undefined: lock_loss_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Happy path: enable=1, transfer mul=8/div=2/ch_div={3,1}, ana_lock=1 from entry to WAIT_LOCK. Required: pll_rst_o high 4 cycles, pll_locked high 3 cycles later; ch_ce[0] every cycle, ch_ce[1] every 3rd cycle starting at cycle 3.
- Bad config: cfg_div=0. Required: next edge ERROR, err_code=1, pll_error=1. A following valid config clears the error and enters RESET_PLL.
- Timeout with retry: ana_lock held 0. Required: 3 attempts (RST_CYCLES+16 cycles each), then ERROR with err_code=2; ana_lock toggling 1,1,0 never locks.
- Loss of lock: ana_lock pulsed low 1 cycle in LOCKED. Required: pll_locked=0 next edge, lock_lost=1, relock succeeds; with PLL_LOCK_CNT_EN, lock_loss_cnt=1.
- Bypass and enable: pll_bypass=1 during WAIT_LOCK gives pll_locked=1 the next edge and channels running. Dropping pll_enable gives IDLE, cfg_ready=0, ch_ce=0. Asserting reset mid-LOCKED clears all outputs immediately.
